// File: rtl/param_fifo.sv
// param_fifo: parametrised single-clock FIFO with first-word fall-through
// output, occupancy count, programmable almost flags, synchronous flush and
// sticky overflow/underflow error flags. Depth need not be a power of two.
module param_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             write,
    input  logic             read,
    input  logic             flush,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dataOut,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_wr_en;
    logic             w_rd_en;
    logic             w_ovf_evt;
    logic             w_udf_evt;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;

    // Status decodes come only from the registered count.
    assign empty        = (r_count == '0);
    assign full         = (r_count == CW'(DEPTH));
    assign almost_empty = (r_count <= CW'(AE_LEVEL));
    assign almost_full  = (r_count >= CW'(AF_LEVEL));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A full FIFO still accepts a write when a read frees a slot this cycle.
    // Flush masks both requests, so it can never raise an error flag.
    assign w_wr_en   = !flush & write & (!full | read);
    assign w_rd_en   = !flush & read & !empty;
    assign w_ovf_evt = !flush & write & full & !read;
    assign w_udf_evt = !flush & read & empty;

    // Explicit compare-and-wrap keeps non-power-of-two depths correct.
    assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

    // Stale entries are never visible: dataOut is forced to zero when empty.
    assign dataOut = empty ? '0 : r_mem[r_rd_ptr];

    // Storage array: written on accepted writes, no reset needed.
    always_ff @(posedge clk) begin
        if (w_wr_en && !rst)
            r_mem[r_wr_ptr] <= dataIn;
    end

    // Pointers and occupancy; flush returns to the empty state.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= w_wr_ptr_nxt;
            if (w_rd_en) r_rd_ptr <= w_rd_ptr_nxt;
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new event in the clr_err cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_evt | (r_overflow  & !clr_err);
            r_underflow <= w_udf_evt | (r_underflow & !clr_err);
        end
    end

endmodule
